// File: rtl/mandelbrot_frame_ctrl_if.sv
// Engine and clear-write bundle between the frame sequencer and mandelbrot_top.
//   man_en/man_x0/man_y0/man_step : engine launch pulse and view window (ctrl -> engine)
//   man_done                      : engine frame complete pulse (engine -> ctrl)
//   clr_vld/clr_adr/clr_dat       : index memory clear write (ctrl -> FIFO mux)
//   clr_rdy                       : clear write accepted (FIFO mux -> ctrl)
// master = frame controller side, slave = engine / memory side.
interface mandelbrot_frame_ctrl_if #(
  parameter int unsigned FPW = 27,
  parameter int unsigned AW  = 19,
  parameter int unsigned DW  = 8
);
  logic           man_en;
  logic [FPW-1:0] man_x0;
  logic [FPW-1:0] man_y0;
  logic [FPW-1:0] man_step;
  logic           man_done;
  logic           clr_vld;
  logic           clr_rdy;
  logic [AW-1:0]  clr_adr;
  logic [DW-1:0]  clr_dat;

  modport master (
    output man_en, man_x0, man_y0, man_step, clr_vld, clr_adr, clr_dat,
    input  man_done, clr_rdy
  );

  modport slave (
    input  man_en, man_x0, man_y0, man_step, clr_vld, clr_adr, clr_dat,
    output man_done, clr_rdy
  );
endinterface

// File: rtl/mandelbrot_frame_ctrl.sv
// Frame sequencer for mandelbrot_top (man_clk domain).
// Per frame: optional index-memory clear, window computation from centre and step,
// one-cycle engine launch, wait for done, then (auto mode) zoom in and repeat.
// Ports:
//   clk, clk_en, rst      : clock, clock enable (all state holds when low), sync active-high reset
//   start, stop           : begin sequence (IDLE only) / finish current frame then idle (sticky)
//   auto_en, clr_en       : loop with zoom / clear memory before each frame
//   clr_val               : index value written during clear
//   cx, cy, step0         : view centre (signed) and initial step (unsigned), sampled on start
//   bus                   : engine launch/done and clear write handshake (master side)
//   busy, frame_cnt       : not idle / completed frames (wrapping)
module mandelbrot_frame_ctrl #(
  parameter int unsigned FPW   = 27,
  parameter int unsigned AW    = 19,
  parameter int unsigned DW    = 8,
  parameter int unsigned NPIX  = 307200,
  parameter int unsigned HALFX = 320,
  parameter int unsigned HALFY = 240,
  parameter int unsigned ZS    = 4
) (
  input  logic                   clk,
  input  logic                   clk_en,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   auto_en,
  input  logic                   clr_en,
  input  logic [DW-1:0]          clr_val,
  input  logic [FPW-1:0]         cx,
  input  logic [FPW-1:0]         cy,
  input  logic [FPW-1:0]         step0,
  mandelbrot_frame_ctrl_if.master bus,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  localparam logic [FPW-1:0] HalfxW  = FPW'(HALFX);
  localparam logic [FPW-1:0] HalfyW  = FPW'(HALFY);
  localparam logic [AW-1:0]  LastAdr = AW'(NPIX - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StClear,
    StLaunch,
    StRun,
    StZoom
  } state_e;

  state_e         state_q, state_d;
  logic [FPW-1:0] cx_q, cx_d;
  logic [FPW-1:0] cy_q, cy_d;
  logic [FPW-1:0] step_q, step_d;
  logic [FPW-1:0] x0_q, x0_d;
  logic [FPW-1:0] y0_q, y0_d;
  logic [FPW-1:0] mstep_q, mstep_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [15:0]    frame_q, frame_d;
  logic           stop_q, stop_d;

  // Products keep only the FPW LSBs; subtraction then wraps in two's complement.
  logic [FPW-1:0] prod_x;
  logic [FPW-1:0] prod_y;
  logic [FPW-1:0] zoom_step;

  always_comb begin
    prod_x    = step_q * HalfxW;
    prod_y    = step_q * HalfyW;
    zoom_step = step_q - (step_q >> ZS);
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    step_d  = step_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    mstep_d = mstep_q;
    adr_d   = adr_q;
    frame_d = frame_q;
    stop_d  = stop_q;

    if (state_q != StIdle && stop) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cx_d    = cx;
          cy_d    = cy;
          step_d  = step0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        mstep_d = step_q;
        x0_d    = cx_q - prod_x;
        y0_d    = cy_q - prod_y;
        state_d = clr_en ? StClear : StLaunch;
      end
      StClear: begin
        // clr_vld is implied by the state, so only the ready side gates progress.
        if (bus.clr_rdy) begin
          if (adr_q == LastAdr) begin
            adr_d   = '0;
            state_d = StLaunch;
          end else begin
            adr_d = adr_q + AW'(1);
          end
        end
      end
      StLaunch: begin
        state_d = StRun;
      end
      StRun: begin
        if (bus.man_done) begin
          frame_d = frame_q + 16'd1;
          if (stop_q || stop || !auto_en) begin
            stop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StZoom;
          end
        end
      end
      StZoom: begin
        // Never let the step collapse to zero; hold the last nonzero value instead.
        if (zoom_step != '0) begin
          step_d = zoom_step;
        end
        state_d = StCalc;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cx_q    <= '0;
      cy_q    <= '0;
      step_q  <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      mstep_q <= '0;
      adr_q   <= '0;
      frame_q <= '0;
      stop_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      step_q  <= step_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      mstep_q <= mstep_d;
      adr_q   <= adr_d;
      frame_q <= frame_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    bus.man_en   = (state_q == StLaunch);
    bus.man_x0   = x0_q;
    bus.man_y0   = y0_q;
    bus.man_step = mstep_q;
    bus.clr_vld  = (state_q == StClear);
    bus.clr_adr  = adr_q;
    bus.clr_dat  = clr_val;
    busy         = (state_q != StIdle);
    frame_cnt    = frame_q;
  end

endmodule

// File: tb/tb_mandelbrot_frame_ctrl.sv
module tb_mandelbrot_frame_ctrl;
  localparam int unsigned FPW = 27;
  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 8;

  logic           clk = 1'b0;
  logic           clk_en, rst, start, stop, auto_en, clr_en;
  logic [DW-1:0]  clr_val;
  logic [FPW-1:0] cx, cy, step0;
  logic           busy;
  logic [15:0]    frame_cnt;
  int             checks = 0;
  int             errors = 0;

  mandelbrot_frame_ctrl_if #(.FPW(FPW), .AW(AW), .DW(DW)) bus ();

  mandelbrot_frame_ctrl #(
    .FPW(FPW), .AW(AW), .DW(DW), .NPIX(16), .HALFX(320), .HALFY(240), .ZS(4)
  ) dut (
    .clk(clk), .clk_en(clk_en), .rst(rst), .start(start), .stop(stop),
    .auto_en(auto_en), .clr_en(clr_en), .clr_val(clr_val), .cx(cx), .cy(cy),
    .step0(step0), .bus(bus), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; stop = 1'b0; auto_en = 1'b0; clr_en = 1'b0;
    clr_val = '0; cx = '0; cy = '0; step0 = '0; bus.man_done = 1'b0; bus.clr_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    bus.man_done = 1'b1;
    tick();
    bus.man_done = 1'b0;
  endtask

  task automatic run_to_launch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.man_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset_single();
    do_reset();
    checks++;
    if (busy !== 1'b0 || bus.man_en !== 1'b0 || bus.clr_vld !== 1'b0 || bus.clr_adr !== '0 ||
        frame_cnt !== 16'd0 || bus.man_x0 !== '0 || bus.man_y0 !== '0 || bus.man_step !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b en=%b vld=%b adr=%h cnt=%h x0=%h step=%h (want all 0)",
               busy, bus.man_en, bus.clr_vld, bus.clr_adr, frame_cnt, bus.man_x0, bus.man_step);
    end
    step0 = 27'h100; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.man_en !== 1'b0) begin
      errors++; $display("FAIL calc_cycle busy=%b en=%b want 1 0", busy, bus.man_en);
    end
    tick();
    checks++;
    if (bus.man_en !== 1'b1) begin
      errors++; $display("FAIL launch_latency en=%b want 1", bus.man_en);
    end
    // x0 = -320*0x100 = -0x14000, y0 = -240*0x100 = -0xF000 (27-bit two's complement)
    checks++;
    if (bus.man_x0 !== 27'h7FEC000 || bus.man_y0 !== 27'h7FF1000 || bus.man_step !== 27'h100) begin
      errors++;
      $display("FAIL window x0=%h y0=%h step=%h want 7fec000 7ff1000 100",
               bus.man_x0, bus.man_y0, bus.man_step);
    end
    tick();
    tick(); tick();
    checks++;
    if (bus.man_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL run_wait en=%b busy=%b want 0 1", bus.man_en, busy);
    end
    pulse_done();
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd1) begin
      errors++; $display("FAIL single_done busy=%b cnt=%0d want 0 1", busy, frame_cnt);
    end
  endtask

  task automatic test_clear();
    int nacc;
    bit rdy;
    do_reset();
    clr_en = 1'b1; clr_val = 8'hA5; step0 = 27'h100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    nacc = 0;
    rdy = 1'b1;
    for (int c = 0; c < 64 && nacc < 16; c++) begin
      bus.clr_rdy = rdy;
      checks++;
      if (bus.clr_vld !== 1'b1 || bus.clr_adr !== AW'(nacc) || bus.clr_dat !== 8'hA5 ||
          bus.man_en !== 1'b0) begin
        errors++;
        $display("FAIL clear_write vld=%b adr=%0d dat=%h en=%b want 1 %0d a5 0",
                 bus.clr_vld, bus.clr_adr, bus.clr_dat, bus.man_en, nacc);
      end
      if (rdy) nacc++;
      rdy = !rdy;
      tick();
    end
    bus.clr_rdy = 1'b0;
    checks++;
    if (nacc !== 16) begin
      errors++; $display("FAIL clear_count got %0d want 16", nacc);
    end
    checks++;
    if (bus.man_en !== 1'b1 || bus.clr_vld !== 1'b0 || bus.clr_adr !== '0) begin
      errors++;
      $display("FAIL clear_to_launch en=%b vld=%b adr=%0d want 1 0 0",
               bus.man_en, bus.clr_vld, bus.clr_adr);
    end
    tick();
    pulse_done();
  endtask

  task automatic test_auto_zoom();
    bit ok;
    do_reset();
    auto_en = 1'b1; step0 = 27'h100; start = 1'b1;
    tick();
    start = 1'b0;
    run_to_launch(ok);
    checks++;
    if (!ok || bus.man_step !== 27'h100) begin
      errors++; $display("FAIL zoom_f1 ok=%b step=%h want 1 100", ok, bus.man_step);
    end
    tick();
    pulse_done();
    run_to_launch(ok);
    // 0x100 - 0x10 = 0xF0; x0 = -320*0xF0 = -0x12C00
    checks++;
    if (!ok || bus.man_step !== 27'hF0 || bus.man_x0 !== 27'h7FED400) begin
      errors++;
      $display("FAIL zoom_f2 ok=%b step=%h x0=%h want 1 f0 7fed400", ok, bus.man_step, bus.man_x0);
    end
    tick();
    pulse_done();
    run_to_launch(ok);
    // 0xF0 - 0xF = 0xE1
    checks++;
    if (!ok || bus.man_step !== 27'hE1 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL zoom_f3 ok=%b step=%h cnt=%0d want 1 e1 2", ok, bus.man_step, frame_cnt);
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pulse_done();
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd3) begin
      errors++; $display("FAIL zoom_stop busy=%b cnt=%0d want 0 3", busy, frame_cnt);
    end
  endtask

  task automatic test_saturate_stop();
    bit ok;
    do_reset();
    auto_en = 1'b1; step0 = 27'h1; start = 1'b1;
    tick();
    start = 1'b0;
    run_to_launch(ok);
    // x0 = -320 = 27'h7FFFEC0
    checks++;
    if (!ok || bus.man_step !== 27'h1 || bus.man_x0 !== 27'h7FFFEC0) begin
      errors++;
      $display("FAIL sat_f1 ok=%b step=%h x0=%h want 1 1 7fffec0", ok, bus.man_step, bus.man_x0);
    end
    tick();
    pulse_done();
    run_to_launch(ok);
    checks++;
    if (!ok || bus.man_step !== 27'h1) begin
      errors++; $display("FAIL sat_f2 ok=%b step=%h want 1 1", ok, bus.man_step);
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL stop_no_abort busy=%b want 1", busy);
    end
    pulse_done();
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++; $display("FAIL stop_idle busy=%b cnt=%0d want 0 2", busy, frame_cnt);
    end
  endtask

  task automatic test_ignore_freeze();
    bit ok;
    do_reset();
    cx = 27'h1000; cy = 27'h7FFF800; step0 = 27'h40; start = 1'b1;
    tick();
    start = 1'b0;
    run_to_launch(ok);
    // x0 = 0x1000 - 0x5000 = -0x4000; y0 = -0x800 - 0x3C00 = -0x4400
    checks++;
    if (!ok || bus.man_x0 !== 27'h7FFC000 || bus.man_y0 !== 27'h7FFBC00) begin
      errors++;
      $display("FAIL offset_window ok=%b x0=%h y0=%h want 1 7ffc000 7ffbc00",
               ok, bus.man_x0, bus.man_y0);
    end
    clk_en = 1'b0;
    tick(); tick();
    checks++;
    if (bus.man_en !== 1'b1 || bus.man_step !== 27'h40 || busy !== 1'b1) begin
      errors++;
      $display("FAIL freeze_launch en=%b step=%h busy=%b want 1 40 1", bus.man_en, bus.man_step, busy);
    end
    clk_en = 1'b1;
    tick();
    checks++;
    if (bus.man_en !== 1'b0) begin
      errors++; $display("FAIL launch_once en=%b want 0", bus.man_en);
    end
    cx = 27'h0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (bus.man_en !== 1'b0 || bus.man_x0 !== 27'h7FFC000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run en=%b x0=%h busy=%b want 0 7ffc000 1", bus.man_en, bus.man_x0, busy);
    end
    clk_en = 1'b0; bus.man_done = 1'b1;
    tick(); tick();
    bus.man_done = 1'b0; clk_en = 1'b1;
    checks++;
    if (busy !== 1'b1 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL freeze_done busy=%b cnt=%0d want 1 0", busy, frame_cnt);
    end
    pulse_done();
    pulse_done();
    tick();
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd1 || bus.man_en !== 1'b0) begin
      errors++;
      $display("FAIL spurious_done busy=%b cnt=%0d en=%b want 0 1 0", busy, frame_cnt, bus.man_en);
    end
  endtask

  task automatic test_reset_mid_clear();
    // Frame count is 1 from the previous scenario; reset must clear it.
    clr_en = 1'b1; clr_val = 8'h3C; bus.clr_rdy = 1'b1; step0 = 27'h100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus.clr_vld !== 1'b1 || bus.clr_adr !== AW'(7)) begin
      errors++; $display("FAIL mid_clear vld=%b adr=%0d want 1 7", bus.clr_vld, bus.clr_adr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.clr_vld !== 1'b0 || bus.clr_adr !== '0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_clear vld=%b adr=%0d busy=%b cnt=%0d want 0 0 0 0",
               bus.clr_vld, bus.clr_adr, busy, frame_cnt);
    end
    bus.clr_rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset_single();
    test_clear();
    test_auto_zoom();
    test_saturate_stop();
    test_ignore_freeze();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
